// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller:
// state encodings and the default trial-word width.
package sar_search_pkg;

    localparam int SAR_WIDTH_DEF = 4;

    typedef enum logic {
        SAR_IDLE  = 1'b0,
        SAR_TRIAL = 1'b1
    } sar_state_e;

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search controller: drives a trial word to an external
// comparator and resolves the unknown MSB-first. Optional early exit: SAR_EARLY_EXIT_EN.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_ge,
`ifdef SAR_EARLY_EXIT_EN
    input  logic             cmp_eq,
`endif
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Handshake: start is taken only in IDLE (ignored while busy, no queueing);
    // done is a one-cycle pulse and result is valid from that cycle until the next done.

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] kept;
    logic             exit_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SAR_IDLE;
            trial_q  <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        bit_mask = WIDTH'(1) << idx_q;
        // The bit under test survives only if the unknown is at least the trial.
        kept     = cmp_ge ? trial_q : (trial_q & ~bit_mask);
`ifdef SAR_EARLY_EXIT_EN
        exit_now = cmp_eq;
`else
        exit_now = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        unique case (state_q)
            SAR_IDLE: begin
                if (start) begin
                    trial_d = WIDTH'(1) << (WIDTH - 1);
                    idx_d   = IDX_W'(WIDTH - 1);
                    busy_d  = 1'b1;
                    state_d = SAR_TRIAL;
                end
            end
            SAR_TRIAL: begin
                if (exit_now) begin
                    // An exact match ends the search with the word on the bus.
                    result_d = trial_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    trial_d  = '0;
                    idx_d    = '0;
                    state_d  = SAR_IDLE;
                end else if (idx_q == '0) begin
                    result_d = kept;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    trial_d  = '0;
                    state_d  = SAR_IDLE;
                end else begin
                    trial_d = kept | (bit_mask >> 1);
                    idx_d   = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = SAR_IDLE;
            end
        endcase
    end

    assign trial  = trial_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_sar_search.sv
// Scoreboarded bench for sar_search: a behavioural comparator closes the loop,
// directed searches push expected trials/results, a monitor pops and compares.
module tb_sar_search;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         cmp_ge;
    logic [W-1:0] trial;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] unknown;
`ifdef SAR_EARLY_EXIT_EN
    logic         cmp_eq;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] trial_exp_q[$];
    int           len_q[$];
    int           busy_run = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- comparator models ----------------
    assign cmp_ge = (unknown >= trial);
`ifdef SAR_EARLY_EXIT_EN
    assign cmp_eq = (unknown == trial);
`endif

    sar_search #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_ge (cmp_ge),
`ifdef SAR_EARLY_EXIT_EN
        .cmp_eq (cmp_eq),
`endif
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busy_run++;
            if (trial_exp_q.size() == 0) begin
                check("unexpected_trial", int'(trial), -1);
            end else begin
                check("trial", int'(trial), int'(trial_exp_q.pop_front()));
            end
        end else if (done === 1'b1) begin
            if (exp_q.size() == 0 || len_q.size() == 0) begin
                check("unexpected_done", int'(result), -1);
            end else begin
                check("result", int'(result), int'(exp_q.pop_front()));
                check("busy_cycles", busy_run, len_q.pop_front());
            end
            busy_run = 0;
        end else begin
            busy_run = 0;
        end
    end

    // ---------------- driver tasks ----------------
    // seq packs up to four trials, first trial in the top nibble.
    task automatic push_search(input logic [W-1:0] res, input logic [15:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            trial_exp_q.push_back(seq[15-4*i -: 4]);
        end
        exp_q.push_back(res);
        len_q.push_back(n);
    endtask

    task automatic push_trials_only(input logic [15:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            trial_exp_q.push_back(seq[15-4*i -: 4]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        bit seen = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 30 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                cyc  = k;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        rst     = 1'b1;
        start   = 1'b0;
        unknown = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_trial", int'(trial), 0);
        check("reset_result", int'(result), 0);

        // unknown=11: trials 8,12,10,11, done four negedges after the first trial
        unknown = 4'd11;
        push_search(4'd11, 16'h8CAB, 4);
        pulse_start();
        wait_done(cyc);
        check("latency_11", cyc, 4);
        @(negedge clk);
        check("idle_done_low", int'(done), 0);

        // boundaries: 0 and all-ones
        unknown = 4'd0;
        push_search(4'd0, 16'h8421, 4);
        pulse_start();
        wait_done(cyc);
        @(negedge clk);

        unknown = 4'd15;
        push_search(4'd15, 16'h8CEF, 4);
        pulse_start();
        wait_done(cyc);
        @(negedge clk);

        // start re-pulsed during the second trial is ignored
        unknown = 4'd5;
        push_search(4'd5, 16'h8465, 4);
        pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        repeat (6) @(negedge clk);

        // reset during the third trial of unknown=7 (trials 8,4,6 seen)
        unknown = 4'd7;
        push_trials_only(16'h8460, 3);
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_trial", int'(trial), 0);
        check("midrst_result", int'(result), 0);

        unknown = 4'd9;
        push_search(4'd9, 16'h8CA9, 4);
        pulse_start();
        wait_done(cyc);
        @(negedge clk);

        // start held high: back-to-back searches for 6 then 13
        unknown = 4'd6;
`ifdef SAR_EARLY_EXIT_EN
        push_search(4'd6, 16'h8460, 3);
`else
        push_search(4'd6, 16'h8467, 4);
`endif
        push_search(4'd13, 16'h8CED, 4);
        start = 1'b1;
        wait_done(cyc);
        unknown = 4'd13;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("done_spacing", cyc + 1, 5);
        @(negedge clk);

`ifdef SAR_EARLY_EXIT_EN
        // exact match on the first trial ends after one trial cycle
        unknown = 4'd8;
        push_search(4'd8, 16'h8000, 1);
        pulse_start();
        wait_done(cyc);
        check("early_latency_8", cyc, 1);
        @(negedge clk);

        unknown = 4'd3;
        push_search(4'd3, 16'h8423, 4);
        pulse_start();
        wait_done(cyc);
        @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        check("pending_results", exp_q.size(), 0);
        check("pending_trials", trial_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
